// File: rtl/mm_in_packer_pkg.sv
// Shared constants and sizing helpers for the matrix-multiply input packer.
// Frame geometry, lane count and packer state encodings live here.
package mm_in_packer_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 8;

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_PAD  = 1'b1;

  // One frame is matrix A followed by matrix B, both row-major.
  function automatic int frame_elems(input int m, input int n1, input int n2);
    return m * n1 + n1 * n2;
  endfunction

  function automatic int frame_words(input int f);
    return (f + LANES - 1) / LANES;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mm_in_packer.sv
// Packs a byte-wide element stream (A then B) into 32-bit AXI-stream words,
// zero-padding the last word of each frame and flagging framing errors.
module mm_in_packer
  import mm_in_packer_pkg::*;
#(
  parameter int M   = 16,
  parameter int N1  = 16,
  parameter int N2  = 16,
  parameter int D_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [D_W-1:0] e_data,
  input  logic           e_valid,
  output logic           e_ready,
  input  logic           e_last,
  output logic [31:0]    x_TDATA,
  output logic           x_TVALID,
  input  logic           x_TREADY,
  output logic           x_TLAST,
  output logic           frame_err
);

  localparam int F  = frame_elems(M, N1, N2);
  localparam int W  = frame_words(F);
  localparam int CW = cnt_width(F);
  localparam int WW = cnt_width(W);
  localparam logic [CW-1:0] LAST_ELEM = CW'(F - 1);
  localparam logic [WW-1:0] LAST_WORD = WW'(W - 1);

  logic [0:0]     state;
  logic [1:0]     lane_cnt;
  logic [CW-1:0]  elem_cnt;
  logic [WW-1:0]  word_cnt;
  logic [D_W-1:0] lane_reg [0:LANES-1];
  logic [31:0]    pad_word;

  logic        out_free;
  logic        at_last;
  logic        full_word;
  logic        accept;
  logic        load;
  logic [31:0] word_next;
  logic [31:0] load_data;

  assign out_free  = !x_TVALID || x_TREADY;
  assign at_last   = (elem_cnt == LAST_ELEM);
  assign full_word = (lane_cnt == 2'd3);

  // Only a lane-3 element needs the output register free; a short final word
  // may be parked in PAD until the register drains.
  assign e_ready = (state == ST_PAD) ? 1'b0 : (full_word ? out_free : 1'b1);
  assign accept  = e_valid && e_ready;

  always_comb begin
    word_next = '0;
    for (int k = 0; k < LANES; k++) begin
      if (k < int'(lane_cnt)) word_next[k*D_W +: D_W] = lane_reg[k];
    end
    word_next[{lane_cnt, 3'b000} +: D_W] = e_data;
  end

  assign load = (state == ST_PAD) ? out_free
                                  : (accept && (full_word || at_last) && out_free);
  assign load_data = (state == ST_PAD) ? pad_word : word_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_FILL;
      lane_cnt <= '0;
      elem_cnt <= '0;
      pad_word <= '0;
      for (int k = 0; k < LANES; k++) lane_reg[k] <= '0;
    end else begin
      if (accept) begin
        lane_reg[lane_cnt] <= e_data;
        lane_cnt <= at_last ? 2'd0 : lane_cnt + 2'd1;
        elem_cnt <= at_last ? '0 : elem_cnt + 1'b1;
        if (at_last && !full_word && !out_free) begin
          pad_word <= word_next;
          state    <= ST_PAD;
        end
      end
      if (state == ST_PAD && out_free) state <= ST_FILL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_TDATA  <= '0;
      x_TVALID <= 1'b0;
      x_TLAST  <= 1'b0;
      word_cnt <= '0;
    end else if (load) begin
      x_TDATA  <= load_data;
      x_TVALID <= 1'b1;
      x_TLAST  <= (word_cnt == LAST_WORD);
      word_cnt <= (word_cnt == LAST_WORD) ? '0 : word_cnt + 1'b1;
    end else if (x_TREADY) begin
      x_TVALID <= 1'b0;
      x_TLAST  <= 1'b0;
    end
  end

  // Sticky: a misplaced or missing e_last never disturbs packing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err <= 1'b0;
    end else if (accept && (e_last != at_last)) begin
      frame_err <= 1'b1;
    end
  end

endmodule
